// File: rtl/ddr3_cmd_decoder_if.sv
// DDR3 command bus as seen by a DRAM-side monitor, plus the monitor's decoded results.
// master = controller/bench side driving the bus, slave = the decoder.
interface ddr3_cmd_decoder_if #(
  parameter int unsigned ADDR_BITS = 13
);
  logic                 rst_n_in;
  logic                 cke;
  logic                 cs_n;
  logic                 ras_n;
  logic                 cas_n;
  logic                 we_n;
  logic [2:0]           ba;
  logic [ADDR_BITS-1:0] addr;

  logic                 cmd_valid;
  logic [2:0]           cmd_code;
  logic [2:0]           cmd_ba;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [ADDR_BITS-1:0] mr0;
  logic [ADDR_BITS-1:0] mr1;
  logic [ADDR_BITS-1:0] mr2;
  logic [ADDR_BITS-1:0] mr3;
  logic [7:0]           bank_open;
  logic                 init_done;
  logic                 err;
  logic [2:0]           err_code;
  logic                 err_sticky;

  modport master (
    output rst_n_in, cke, cs_n, ras_n, cas_n, we_n, ba, addr,
    input  cmd_valid, cmd_code, cmd_ba, cmd_addr, mr0, mr1, mr2, mr3,
           bank_open, init_done, err, err_code, err_sticky
  );

  modport slave (
    input  rst_n_in, cke, cs_n, ras_n, cas_n, we_n, ba, addr,
    output cmd_valid, cmd_code, cmd_ba, cmd_addr, mr0, mr1, mr2, mr3,
           bank_open, init_done, err, err_code, err_sticky
  );
endinterface

// File: rtl/ddr3_cmd_decoder.sv
// DRAM-side DDR3 command decoder: tracks the init sequence, mode registers and open banks,
// and flags ordering/timing violations. Inputs are sampled once, then decoded a cycle later.
module ddr3_cmd_decoder #(
  parameter int unsigned ADDR_BITS = 13,
  parameter int unsigned TMRD      = 4,
  parameter int unsigned TMOD      = 12,
  parameter int unsigned TZQINIT   = 512,
  parameter int unsigned TRCD      = 6
) (
  input  logic              clk,
  input  logic              rst,
  ddr3_cmd_decoder_if.slave bus
);
  localparam int unsigned CW = 10;
  localparam int unsigned ZW = $clog2(TZQINIT + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam logic [2:0] C_MRS = 3'd0, C_REF = 3'd1, C_PRE = 3'd2, C_ACT = 3'd3;
  localparam logic [2:0] C_WR  = 3'd4, C_RD  = 3'd5, C_ZQC = 3'd6, C_NOP = 3'd7;
  localparam logic [2:0] E_NONE = 3'd0, E_ORDER = 3'd1, E_TMRD = 3'd2, E_TMOD = 3'd3;
  localparam logic [2:0] E_TZQ  = 3'd4, E_BANK  = 3'd5, E_RWCL = 3'd6, E_TRCD = 3'd7;

  typedef enum logic [3:0] {
    S_RST, S_CKE, S_MR2, S_MR3, S_MR1, S_MR0, S_ZQ, S_ZQW, S_RDY
  } state_t;

  state_t               r_state, w_state_nxt, w_mr_adv;
  logic                 r_rst_n, r_cke, r_cs_n;
  logic [2:0]           r_code, r_ba, w_exp_ba, w_err;
  logic [ADDR_BITS-1:0] r_addr;
  logic [CW-1:0]        r_gap, r_act_cnt, w_gap, w_since;
  logic                 r_gap_vld, r_act_vld, w_is_cmd, w_mr_we, w_act_hit, w_init_nxt;
  logic [2:0]           r_act_ba;
  logic [ZW-1:0]        r_zq, w_zq_nxt;
  logic [7:0]           r_bank_open, w_bank_nxt;
  logic [ADDR_BITS-1:0] r_mr [4];
  logic                 r_cmd_valid, r_init_done, r_err, r_err_sticky;
  logic [2:0]           r_cmd_code, r_cmd_ba, r_err_code;
  logic [ADDR_BITS-1:0] r_cmd_addr;

  // Input sample stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_n <= 1'b0;
      r_cke   <= 1'b0;
      r_cs_n  <= 1'b1;
      r_code  <= C_NOP;
      r_ba    <= '0;
      r_addr  <= '0;
    end else begin
      r_rst_n <= bus.rst_n_in;
      r_cke   <= bus.cke;
      r_cs_n  <= bus.cs_n;
      r_code  <= {bus.ras_n, bus.cas_n, bus.we_n};
      r_ba    <= bus.ba;
      r_addr  <= bus.addr;
    end
  end

  assign w_is_cmd = !r_cs_n && r_cke && (r_code != C_NOP);
  // Effective distance to the previous event: saturates, and reads max when no event is on record
  assign w_gap    = !r_gap_vld ? CNT_MAX : ((r_gap == CNT_MAX) ? CNT_MAX : r_gap + CW'(1));
  assign w_since  = !r_act_vld ? CNT_MAX : ((r_act_cnt == CNT_MAX) ? CNT_MAX : r_act_cnt + CW'(1));

  always_comb begin
    w_exp_ba = 3'd0;
    w_mr_adv = r_state;
    case (r_state)
      S_MR2:   begin w_exp_ba = 3'd2; w_mr_adv = S_MR3; end
      S_MR3:   begin w_exp_ba = 3'd3; w_mr_adv = S_MR1; end
      S_MR1:   begin w_exp_ba = 3'd1; w_mr_adv = S_MR0; end
      S_MR0:   begin w_exp_ba = 3'd0; w_mr_adv = S_ZQ;  end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = E_NONE;
    w_mr_we     = 1'b0;
    w_act_hit   = 1'b0;
    w_bank_nxt  = r_bank_open;
    w_init_nxt  = r_init_done;
    w_zq_nxt    = r_zq;
    case (r_state)
      S_RST: if (r_rst_n) w_state_nxt = S_CKE;
      S_CKE: begin
        if (r_cke) w_state_nxt = S_MR2;
        if (w_is_cmd) w_err = E_ORDER;
      end
      S_MR2, S_MR3, S_MR1, S_MR0: if (w_is_cmd) begin
        if (r_code == C_MRS && r_ba == w_exp_ba) begin
          w_mr_we     = 1'b1;
          w_state_nxt = w_mr_adv;
          if (w_gap < CW'(TMRD)) w_err = E_TMRD;
        end else begin
          w_err = E_ORDER;
        end
      end
      S_ZQ: if (w_is_cmd) begin
        if (r_code == C_ZQC && r_addr[10]) begin
          w_zq_nxt    = ZW'(TZQINIT - 1);
          w_state_nxt = S_ZQW;
          if (w_gap < CW'(TMOD)) w_err = E_TMOD;
        end else begin
          w_err = E_ORDER;
        end
      end
      S_ZQW: begin
        if (w_is_cmd) w_err = E_TZQ;
        w_zq_nxt = r_zq - ZW'(1);
        // Leave one cycle early so a command exactly TZQINIT cycles after ZQCL is legal
        if (r_zq <= ZW'(1)) begin
          w_zq_nxt    = '0;
          w_state_nxt = S_RDY;
          w_init_nxt  = 1'b1;
        end
      end
      S_RDY: if (w_is_cmd) begin
        case (r_code)
          C_ACT: begin
            if (r_bank_open[r_ba]) w_err = E_BANK;
            w_bank_nxt[r_ba] = 1'b1;
            w_act_hit        = 1'b1;
          end
          C_PRE: begin
            if (r_addr[10]) w_bank_nxt = '0;
            else            w_bank_nxt[r_ba] = 1'b0;
          end
          C_RD, C_WR: begin
            if (!r_bank_open[r_ba])                                 w_err = E_RWCL;
            else if (r_ba == r_act_ba && w_since < CW'(TRCD))       w_err = E_TRCD;
          end
          C_MRS: begin
            if (|r_bank_open) w_err = E_BANK;
            w_mr_we = 1'b1;
          end
          C_REF, C_ZQC: if (|r_bank_open) w_err = E_BANK;
          default: ;
        endcase
      end
      default: w_state_nxt = S_RST;
    endcase
    if (!r_rst_n) begin
      w_state_nxt = S_RST;
      w_err       = E_NONE;
      w_mr_we     = 1'b0;
      w_act_hit   = 1'b0;
      w_bank_nxt  = '0;
      w_init_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_RST;
      r_gap        <= '0;
      r_gap_vld    <= 1'b0;
      r_act_cnt    <= '0;
      r_act_vld    <= 1'b0;
      r_act_ba     <= '0;
      r_zq         <= '0;
      r_bank_open  <= '0;
      r_init_done  <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_code   <= '0;
      r_cmd_ba     <= '0;
      r_cmd_addr   <= '0;
      r_err        <= 1'b0;
      r_err_code   <= '0;
      r_err_sticky <= 1'b0;
      for (int i = 0; i < 4; i++) r_mr[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_zq        <= w_zq_nxt;
      r_bank_open <= w_bank_nxt;
      r_init_done <= w_init_nxt;
      if (w_is_cmd)               r_gap <= '0;
      else if (r_gap != CNT_MAX)  r_gap <= r_gap + CW'(1);
      if (w_state_nxt == S_RST || r_state == S_RST || r_state == S_CKE) r_gap_vld <= 1'b0;
      else if (w_is_cmd)                                                 r_gap_vld <= 1'b1;
      if (!r_rst_n) begin
        r_act_vld <= 1'b0;
      end else if (w_act_hit) begin
        r_act_vld <= 1'b1;
        r_act_cnt <= '0;
        r_act_ba  <= r_ba;
      end else if (r_act_cnt != CNT_MAX) begin
        r_act_cnt <= r_act_cnt + CW'(1);
      end
      if (!r_rst_n) begin
        for (int i = 0; i < 4; i++) r_mr[i] <= '0;
      end else if (w_mr_we) begin
        r_mr[r_ba[1:0]] <= r_addr;
      end
      r_cmd_valid <= w_is_cmd;
      if (w_is_cmd) begin
        r_cmd_code <= r_code;
        r_cmd_ba   <= r_ba;
        r_cmd_addr <= r_addr;
      end
      r_err      <= (w_err != E_NONE);
      r_err_code <= w_err;
      if (w_err != E_NONE) r_err_sticky <= 1'b1;
    end
  end

  assign bus.cmd_valid  = r_cmd_valid;
  assign bus.cmd_code   = r_cmd_code;
  assign bus.cmd_ba     = r_cmd_ba;
  assign bus.cmd_addr   = r_cmd_addr;
  assign bus.mr0        = r_mr[0];
  assign bus.mr1        = r_mr[1];
  assign bus.mr2        = r_mr[2];
  assign bus.mr3        = r_mr[3];
  assign bus.bank_open  = r_bank_open;
  assign bus.init_done  = r_init_done;
  assign bus.err        = r_err;
  assign bus.err_code   = r_err_code;
  assign bus.err_sticky = r_err_sticky;
endmodule
